io_bram_stream_reader: RTL and testbench

Downstream consumer of the IO BRAM contents written by the GPIO load engine. On `start`, it walks the IO BRAM from `base_address` to `upper_limit` inclusive and streams each word out on a valid/ready interface to the processing engine. It absorbs the BRAM's 1-cycle read latency with a 2-entry output buffer, so it sustains 1 word/cycle under continuous `m_ready`. It shares the IO BRAM read port with the GPIO load engine; only one of the two is active at a time, and arbitration is done in the parent.

---
 rtl/io_bram_stream_reader_pkg.sv | 16 +
 rtl/io_stream_skid2.sv | 56 +++++
 rtl/io_bram_stream_reader.sv | 127 ++++++++++++
 tb/tb_io_bram_stream_reader.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/io_bram_stream_reader_pkg.sv
// Shared IO BRAM geometry and the reader's local FSM encoding.
package io_bram_stream_reader_pkg;

    localparam int IO_BRAM_ADDR_SIZE_BITS_NB = 10;
    localparam int IO_BRAM_WORD_SIZE_BITS_NB = 32;

    // Output buffer depth; also the cap on buffered plus in-flight words.
    localparam int SKID_DEPTH = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } stream_state_t;

endpackage

// File: rtl/io_stream_skid2.sv
// Two-entry FIFO holding {last, data} words between the BRAM read port and the stream output.
module io_stream_skid2 #(
    parameter int W = 33
) (
    input  logic         Clk,
    input  logic         RESET,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] head,
    output logic [1:0]   count
);

    logic       wr_ptr_reg;
    logic       rd_ptr_reg;
    logic [1:0] count_reg;
    logic [W-1:0] slot_data [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_slot
            logic [W-1:0] slot_reg;

            always_ff @(posedge Clk or posedge RESET) begin
                if (RESET) begin
                    slot_reg <= '0;
                end else if (push && !flush && (wr_ptr_reg == 1'(gi))) begin
                    slot_reg <= push_data;
                end
            end

            assign slot_data[gi] = slot_reg;
        end
    endgenerate

    always_ff @(posedge Clk or posedge RESET) begin
        if (RESET) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else if (flush) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push) wr_ptr_reg <= ~wr_ptr_reg;
            if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
            count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head  = slot_data[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/io_bram_stream_reader.sv
// Walks the IO BRAM from base_address to upper_limit and streams each word on a valid/ready port.
module io_bram_stream_reader
    import io_bram_stream_reader_pkg::*;
#(
    parameter int ADDR_W = IO_BRAM_ADDR_SIZE_BITS_NB,
    parameter int DATA_W = IO_BRAM_WORD_SIZE_BITS_NB
) (
    input  logic              Clk,
    input  logic              RESET,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_address,
    input  logic [ADDR_W-1:0] upper_limit,
    output logic              ready,
    output logic [ADDR_W-1:0] BRAM_addr,
    output logic              BRAM_en,
    input  logic [DATA_W-1:0] BRAM_din,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              done,
    output logic              range_err,
    output logic [ADDR_W:0]   word_count
);

    stream_state_t     state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg;
    logic [ADDR_W-1:0] upper_reg;
    logic              inflight_reg;
    logic              inflight_last_reg;
    logic              done_reg;
    logic              range_err_reg;
    logic [ADDR_W:0]   word_count_reg;

    logic [1:0]        fifo_count;
    logic [DATA_W:0]   fifo_head;
    logic [2:0]        budget;
    logic              pop;
    logic              issue;
    logic              issue_last;
    logic              start_ok;
    logic              start_bad;
    logic              abort_act;

    assign abort_act = abort && (state_reg != ST_IDLE);
    assign start_ok  = (state_reg == ST_IDLE) && start && (base_address <= upper_limit);
    assign start_bad = (state_reg == ST_IDLE) && start && (base_address > upper_limit);

    assign m_valid         = (fifo_count != 2'd0);
    assign {m_last, m_data} = fifo_head;
    assign pop             = m_valid && m_ready;

    // Slots committed after this edge if nothing new is issued: the returning word lands
    // and the accepted word leaves. Using the live pop keeps 1 word/cycle under m_ready.
    assign budget     = {1'b0, fifo_count} + {2'b00, inflight_reg} - {2'b00, pop};
    assign issue_last = (addr_reg == upper_reg);
    assign issue      = (state_reg == ST_READ) && !abort && (budget < 3'(SKID_DEPTH));

    assign BRAM_en    = issue;
    assign BRAM_addr  = addr_reg;
    assign ready      = (state_reg == ST_IDLE);
    assign done       = done_reg;
    assign range_err  = range_err_reg;
    assign word_count = word_count_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start_ok) state_next = ST_READ;
            end
            ST_READ: begin
                if (abort)                    state_next = ST_IDLE;
                else if (issue && issue_last) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (abort)               state_next = ST_IDLE;
                else if (pop && m_last)  state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge RESET) begin
        if (RESET) begin
            state_reg         <= ST_IDLE;
            addr_reg          <= '0;
            upper_reg         <= '0;
            inflight_reg      <= 1'b0;
            inflight_last_reg <= 1'b0;
            done_reg          <= 1'b0;
            range_err_reg     <= 1'b0;
            word_count_reg    <= '0;
        end else begin
            state_reg         <= state_next;
            inflight_reg      <= issue;
            inflight_last_reg <= issue && issue_last;
            done_reg          <= (state_reg == ST_DRAIN) && !abort && pop && m_last;
            range_err_reg     <= start_bad;

            if (start_ok) begin
                addr_reg       <= base_address;
                upper_reg      <= upper_limit;
                word_count_reg <= '0;
            end else begin
                if (pop) word_count_reg <= word_count_reg + 1'b1;
                // Hold at upper_limit so a full-range walk never wraps back to 0.
                if (issue && !issue_last) addr_reg <= addr_reg + 1'b1;
            end
        end
    end

    io_stream_skid2 #(
        .W(DATA_W + 1)
    ) u_skid (
        .Clk       (Clk),
        .RESET     (RESET),
        .push      (inflight_reg),
        .pop       (pop),
        .flush     (abort_act),
        .push_data ({inflight_last_reg, BRAM_din}),
        .head      (fifo_head),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_io_bram_stream_reader.sv
// Scoreboard bench for io_bram_stream_reader: stimulus queues expected words, a negedge monitor checks them.
module tb_io_bram_stream_reader;

    localparam int AW = 4;
    localparam int DW = 16;

    logic          Clk = 1'b0;
    logic          RESET = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          m_ready = 1'b0;
    logic [AW-1:0] base_address = '0;
    logic [AW-1:0] upper_limit = '0;
    logic [DW-1:0] BRAM_din = '0;

    logic          ready;
    logic [AW-1:0] BRAM_addr;
    logic          BRAM_en;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          done;
    logic          range_err;
    logic [AW:0]   word_count;

    logic [DW-1:0] mem [16];
    logic [DW:0]   exp_q [$];
    logic [DW:0]   exp_word;
    logic [DW-1:0] prev_data = '0;
    logic          prev_stall = 1'b0;
    logic          hs;
    int            out_cnt = 0;
    int            n_cmp = 0;
    int            n_err = 0;
    int            cyc, first_v, en_cnt, done_cnt;

    io_bram_stream_reader #(
        .ADDR_W(AW),
        .DATA_W(DW)
    ) dut (
        .Clk          (Clk),
        .RESET        (RESET),
        .start        (start),
        .abort        (abort),
        .base_address (base_address),
        .upper_limit  (upper_limit),
        .ready        (ready),
        .BRAM_addr    (BRAM_addr),
        .BRAM_en      (BRAM_en),
        .BRAM_din     (BRAM_din),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_last       (m_last),
        .done         (done),
        .range_err    (range_err),
        .word_count   (word_count)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        if (BRAM_en) BRAM_din <= mem[BRAM_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // Monitor: samples mid-cycle, so inputs seen here are the ones the next edge uses.
    always @(negedge Clk) begin
        if (RESET) begin
            out_cnt    = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 32'(m_valid), 32'(1));
                chk("hold_data", 32'(m_data), 32'(prev_data));
            end
            hs = m_valid && m_ready;
            if (hs) begin
                chk("exp_q_nonempty", 32'(exp_q.size() != 0), 32'(1));
                if (exp_q.size() != 0) begin
                    exp_word = exp_q.pop_front();
                    chk("m_data", 32'(m_data), 32'(exp_word[DW-1:0]));
                    chk("m_last", 32'(m_last), 32'(exp_word[DW]));
                    $display("word data=0x%0h last=%0d", m_data, m_last);
                end
            end
            if (abort) begin
                out_cnt = 0;
            end else begin
                out_cnt = out_cnt + int'(BRAM_en) - int'(hs);
                if (BRAM_en) chk("read_budget", 32'(out_cnt <= 2), 32'(1));
            end
            prev_stall = m_valid && !m_ready && !abort;
            prev_data  = m_data;
        end
    end

    // Start accepted at the second posedge (edge k); returns at k+1ns.
    task automatic start_stream(input logic [AW-1:0] b, input logic [AW-1:0] u);
        @(posedge Clk); #1;
        base_address = b;
        upper_limit  = u;
        start        = 1'b1;
        if (b <= u) begin
            for (int a = int'(b); a <= int'(u); a++)
                exp_q.push_back({(a == int'(u)), 16'(16'h100 + a)});
        end
        @(posedge Clk); #1;
        start = 1'b0;
        $display("start base=%0d upper=%0d", b, u);
    endtask

    // Polls i cycles after edge k until done; optional 1,0,0,1 m_ready pattern.
    task automatic wait_done(input logic toggle, output int c, output int fv, output int ec);
        logic [3:0] pat;
        pat = 4'b1001;
        c  = -1;
        fv = -1;
        ec = 0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge Clk); #1;
            if (m_valid && fv < 0) fv = i;
            if (done) begin
                c = i;
                break;
            end
            if (BRAM_en) ec++;
            if (toggle) m_ready = pat[i % 4];
        end
        chk("done_seen", 32'(c > 0), 32'(1));
        @(posedge Clk); #1;
        chk("done_one_cycle", 32'(done), 32'(0));
        chk("ready_after_done", 32'(ready), 32'(1));
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 16'(16'h100 + i);

        // Reset state
        #3;
        chk("rst_ready", 32'(ready), 32'(1));
        chk("rst_en", 32'(BRAM_en), 32'(0));
        chk("rst_valid", 32'(m_valid), 32'(0));
        chk("rst_addr", 32'(BRAM_addr), 32'(0));
        chk("rst_wc", 32'(word_count), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        @(posedge Clk); #1;
        RESET = 1'b0;

        // Continuous stream 4..7
        m_ready = 1'b1;
        start_stream(4'd4, 4'd7);
        chk("a_ready_low", 32'(ready), 32'(0));
        chk("a_first_en", 32'(BRAM_en), 32'(1));
        chk("a_first_addr", 32'(BRAM_addr), 32'(4));
        chk("a_no_valid_yet", 32'(m_valid), 32'(0));
        wait_done(1'b0, cyc, first_v, en_cnt);
        chk("a_first_valid_cycle", 32'(first_v), 32'(2));
        chk("a_done_cycle", 32'(cyc), 32'(6));
        chk("a_wc", 32'(word_count), 32'(4));

        // Same range under 1,0,0,1 backpressure
        m_ready = 1'b1;
        start_stream(4'd4, 4'd7);
        wait_done(1'b1, cyc, first_v, en_cnt);
        chk("b_wc", 32'(word_count), 32'(4));
        chk("b_q_empty", 32'(exp_q.size()), 32'(0));

        // Single word
        m_ready = 1'b1;
        start_stream(4'd9, 4'd9);
        chk("c_first_en", 32'(BRAM_en), 32'(1));
        wait_done(1'b0, cyc, first_v, en_cnt);
        chk("c_extra_en", 32'(en_cnt), 32'(0));
        chk("c_done_cycle", 32'(cyc), 32'(3));
        chk("c_wc", 32'(word_count), 32'(1));

        // Reversed range
        start_stream(4'd10, 4'd3);
        chk("d_range_err", 32'(range_err), 32'(1));
        chk("d_ready", 32'(ready), 32'(1));
        chk("d_no_en", 32'(BRAM_en), 32'(0));
        @(posedge Clk); #1;
        chk("d_range_err_pulse", 32'(range_err), 32'(0));
        chk("d_no_valid", 32'(m_valid), 32'(0));
        chk("d_no_en2", 32'(BRAM_en), 32'(0));
        chk("d_wc_held", 32'(word_count), 32'(1));

        // Abort after 5 accepted words
        m_ready = 1'b0;
        start_stream(4'd0, 4'd15);
        repeat (3) begin @(posedge Clk); #1; end
        chk("e_buf_full_valid", 32'(m_valid), 32'(1));
        chk("e_buf_full_no_en", 32'(BRAM_en), 32'(0));
        m_ready = 1'b1;
        repeat (5) begin @(posedge Clk); #1; end
        m_ready = 1'b0;
        abort   = 1'b1;
        @(posedge Clk); #1;
        abort = 1'b0;
        exp_q.delete();
        $display("abort issued");
        chk("e_valid_low", 32'(m_valid), 32'(0));
        chk("e_ready", 32'(ready), 32'(1));
        chk("e_wc", 32'(word_count), 32'(5));
        done_cnt = int'(done);
        repeat (4) begin @(posedge Clk); #1; done_cnt += int'(done); end
        chk("e_no_done", 32'(done_cnt), 32'(0));
        m_ready = 1'b1;
        start_stream(4'd2, 4'd5);
        chk("e2_first_addr", 32'(BRAM_addr), 32'(2));
        wait_done(1'b0, cyc, first_v, en_cnt);
        chk("e2_done_cycle", 32'(cyc), 32'(6));
        chk("e2_wc", 32'(word_count), 32'(4));

        // Full address range
        m_ready = 1'b1;
        start_stream(4'd0, 4'd15);
        wait_done(1'b0, cyc, first_v, en_cnt);
        chk("f_done_cycle", 32'(cyc), 32'(18));
        chk("f_wc", 32'(word_count), 32'(16));

        // Asynchronous reset mid-stream
        m_ready = 1'b0;
        start_stream(4'd0, 4'd15);
        repeat (2) begin @(posedge Clk); #1; end
        @(posedge Clk); #2;
        RESET = 1'b1;
        #1;
        exp_q.delete();
        $display("reset asserted mid-stream");
        chk("g_ready", 32'(ready), 32'(1));
        chk("g_valid", 32'(m_valid), 32'(0));
        chk("g_en", 32'(BRAM_en), 32'(0));
        chk("g_addr", 32'(BRAM_addr), 32'(0));
        chk("g_wc", 32'(word_count), 32'(0));
        @(posedge Clk); #1;
        RESET = 1'b0;
        m_ready = 1'b1;
        start_stream(4'd6, 4'd8);
        wait_done(1'b0, cyc, first_v, en_cnt);
        chk("g2_done_cycle", 32'(cyc), 32'(5));
        chk("g2_wc", 32'(word_count), 32'(3));

        chk("final_q_empty", 32'(exp_q.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
